// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and framing constants for the program loader
package prog_loader_pkg;

  // Loader states; encodings are fixed so debug taps read the same in every build
  typedef enum logic [2:0] {
    ST_LEN0  = 3'd0,
    ST_LEN1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  // Length header is two bytes, little-endian
  localparam int HDR_BYTES      = 2;
  // Image words are 32 bits, sent least-significant byte first
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and memory write bus of the program loader
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Environment side: byte source and memory sink
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - assembles little-endian 32-bit words from accepted bytes
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam int LOW_W = 8 * (BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LOW_W-1:0] low_q, low_d;

  // Place each accepted byte into its lane; the top lane is taken straight from the input
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    low_d      = low_q;
    if (byte_valid_i) begin
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
      for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
        if (byte_cnt_q == CNT_W'(i)) low_d[8*i +: 8] = byte_data_i;
      end
    end
  end

  // Byte counter and partial-word storage; reset drops any partial word
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q <= '0;
      low_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      low_q      <= low_d;
    end
  end

  assign word_valid_o = byte_valid_i && (byte_cnt_q == LAST_BYTE);
  assign word_o       = {byte_data_i, low_q};

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader: byte stream to word memory, holds CPU in reset (option PROG_LOADER_CHECKSUM_EN)
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 10,
  parameter int LEN_W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         done,
  output logic         err
);

  state_e            state_q, state_d;
  logic              in_ready;
  logic              xfer;
  logic              data_xfer;
  logic              word_valid;
  logic [31:0]       word;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_full;
  logic [ADDR_W:0]   word_cnt_q;
  logic              last_word;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              done_q;
  logic              err_q;
  logic              cpu_reset_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign xfer      = bus.in_valid && in_ready;
  assign data_xfer = xfer && (state_q == ST_DATA);
  // Full length as it will be once the high header byte is latched
  assign len_full  = {bus.in_data, len_q[7:0]};
  // word_cnt carries one extra bit so a full-depth image never wraps
  assign last_word = (LEN_W'(word_cnt_q) + LEN_W'(1)) == len_q;

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .byte_valid_i (data_xfer),
    .byte_data_i  (bus.in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_LEN0;
    else       state_q <= state_d;
  end

  // Next-state: header parse, length check, word counting, optional checksum
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LEN0: if (xfer) state_d = ST_LEN1;
      ST_LEN1: begin
        if (xfer) begin
          if (len_full == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else if (len_full > LEN_W'(MEM_WORDS)) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_valid && last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (xfer) state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERROR;
`else
        state_d = ST_ERROR;
`endif
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  // Outputs decoded from state: ready only while bytes are still expected
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_LEN0, ST_LEN1, ST_DATA: in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK:                  in_ready = 1'b1;
`endif
      default:                   in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;
  end

  // Length header capture
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0;
    end else if (xfer && state_q == ST_LEN0) begin
      len_q[7:0] <= bus.in_data;
    end else if (xfer && state_q == ST_LEN1) begin
      len_q <= len_full;
    end
  end

  // Memory write port: one registered strobe per completed word, addresses from 0
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= word_valid;
      if (word_valid) begin
        mem_addr_q  <= word_cnt_q[ADDR_W-1:0];
        mem_wdata_q <= word;
        word_cnt_q  <= word_cnt_q + 1'b1;
      end
    end
  end

  // Sticky status, registered one cycle behind the terminal state
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      done_q      <= (state_q == ST_DONE);
      err_q       <= (state_q == ST_ERROR);
      cpu_reset_q <= (state_q != ST_DONE);
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running XOR over data bytes only; the header is excluded
  always_ff @(posedge clk) begin
    if (reset)          csum_q <= 8'h00;
    else if (data_xfer) csum_q <= csum_q ^ bus.in_data;
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against an image-level model
module tb_prog_loader;

  localparam int MEM_WORDS = 1024;
  localparam int ADDR_W    = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_reset, done, err;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .LEN_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed write log and status timing
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cyc = -1;
  int          err_cyc = -1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we) begin
        wr_addr.push_back(int'(bus.mem_addr));
        wr_data.push_back(bus.mem_wdata);
        wr_cyc.push_back(cyc);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (err && err_cyc < 0) err_cyc = cyc;
    end
  end

  // Reference image and expected strobe timing
  logic [31:0] img [MEM_WORDS];
  int          word_edge[$];
  int          last_edge;
  int          gap_mode = 0;

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    word_edge.delete();
    done_cyc = -1;
    err_cyc  = -1;
  endtask

  task automatic fill_img(input int len);
    for (int i = 0; i < len; i++) img[i] = $urandom;
  endtask

  // Ends half a cycle past a rising edge with the loader out of reset
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, '0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
    @(negedge clk);
    check("ready_after_reset", bus.in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Offers one byte (after an optional idle gap) and returns the edge it was taken on
  task automatic send_byte(input logic [7:0] b, output int edge_o);
    int g;
    g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
    repeat (g) begin
      bus.in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    edge_o = -1;
    for (int t = 0; t < 40 && edge_o < 0; t++) begin
      @(negedge clk);
      if (bus.in_ready) edge_o = cyc + 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    if (edge_o < 0) check("send_timeout", 1'b0, 1'b1);
  endtask

  // Streams header + image (+ checksum) and compares against the image-level expectation
  task automatic run_image(input int len, input logic [7:0] bad);
    logic [15:0] hdr;
    logic [7:0]  b;
    logic [7:0]  x;
    logic        overflow;
    logic        good;
    int          e;
    int          n;
    hdr = 16'(len);
    x = 8'h00;
    overflow = (len > MEM_WORDS);
    send_byte(hdr[7:0], e);
    send_byte(hdr[15:8], e);
    last_edge = e;
    if (!overflow) begin
      for (int i = 0; i < len; i++) begin
        for (int k = 0; k < 4; k++) begin
          b = img[i][8*k +: 8];
          x ^= b;
          send_byte(b, e);
        end
        word_edge.push_back(e);
        last_edge = e;
      end
    end
    good = !overflow;
`ifdef PROG_LOADER_CHECKSUM_EN
    if (!overflow) begin
      send_byte(x ^ bad, e);
      last_edge = e;
      good = (bad == 8'h00);
    end
`endif
    repeat (overflow ? 20 : 3) @(posedge clk);
    @(negedge clk);
    n = overflow ? 0 : len;
    check("n_writes", wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check("wr_addr", wr_addr[i], i);
      check("wr_data", wr_data[i], img[i]);
      check("wr_latency", wr_cyc[i], word_edge[i]);
    end
    check("done", done, good);
    check("err", err, !good);
    check("cpu_reset", cpu_reset, !good);
    check("in_ready_end", bus.in_ready, 1'b0);
    if (good) check("done_cycle", done_cyc, last_edge + 1);
    else      check("err_cycle", err_cyc, last_edge + 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int len;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Single word 32'h00500013, no gaps
    gap_mode = 0;
    do_reset();
    img[0] = 32'h00500013;
    run_image(1, 8'h00);

`ifdef PROG_LOADER_CHECKSUM_EN
    // DEADBEEF: XOR of data bytes is 8'h22; a wrong checksum must fail the load
    do_reset();
    img[0] = 32'hDEADBEEF;
    run_image(1, 8'h00);
    do_reset();
    img[0] = 32'hDEADBEEF;
    run_image(1, 8'h01);
`endif

    // Three words with valid toggling every other cycle
    gap_mode = 1;
    fill_img(3);
    do_reset();
    run_image(3, 8'h00);

    // Empty image
    gap_mode = 0;
    do_reset();
    run_image(0, 8'h00);

    // Length 1025 exceeds memory depth
    do_reset();
    run_image(1025, 8'h00);

    // Reset after 6 of 8 data bytes, then a fresh full image
    do_reset();
    fill_img(2);
    send_byte(8'h02, e);
    send_byte(8'h00, e);
    for (int k = 0; k < 6; k++) send_byte(img[k / 4][8*(k % 4) +: 8], e);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("partial_writes", wr_addr.size(), 1);
    do_reset();
    fill_img(2);
    run_image(2, 8'h00);

    // Random images with random gaps
    gap_mode = 2;
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(1, 12));
      fill_img(len);
      do_reset();
      run_image(len, 8'h00);
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    for (int r = 0; r < 2; r++) begin
      len = int'($urandom_range(0, 4));
      fill_img(len);
      do_reset();
      run_image(len, 8'($urandom_range(1, 255)));
    end
`endif

    // Full-depth image: last address MEM_WORDS-1, no counter wrap
    gap_mode = 0;
    fill_img(MEM_WORDS);
    do_reset();
    run_image(MEM_WORDS, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
